axi4_burst_slave: RTL and testbench
===================================

Name: axi4_burst_slave

Overview:
Parametrised successor to the team's AXI4 memory-mapped slave. Supports all three burst types (FIXED/INCR/WRAP), byte strobes, DECERR/SLVERR distinction and configurable data width. A single-port internal memory array is shared by the write and read FSMs through a per-cycle arbiter. It sits behind the interconnect as a leaf memory target.

Parameters:
DATA_W, 32, data bus width in bits (32, 64 or 128)
ADDR_W, 16, byte address width
MEM_DEPTH, 1024, memory depth in DATA_W-bit words
(derived) NB = DATA_W/8, BSH = log2(NB)

Ports:
ACLK  in  1  clock
ARESET  in  1  reset; one clock; reset is synchronous and active-high
AWADDR  in  ADDR_W  write start byte address
AWLEN  in  8  beats minus 1
AWSIZE  in  3  log2 bytes per beat
AWBURST  in  2  0=FIXED 1=INCR 2=WRAP 3=reserved
AWVALID/AWREADY  in/out  1  write address handshake
WDATA  in  DATA_W  write data
WSTRB  in  NB  byte enables
WLAST  in  1  last write beat
WVALID/WREADY  in/out  1  write data handshake
BRESP  out  2  write response
BVALID/BREADY  out/in  1  response handshake
ARADDR  in  ADDR_W  read start byte address
ARLEN  in  8  beats minus 1
ARSIZE  in  3  log2 bytes per beat
ARBURST  in  2  as AWBURST
ARVALID/ARREADY  in/out  1  read address handshake
RDATA  out  DATA_W  read data
RRESP  out  2  read response
RLAST  out  1  last read beat
RVALID/RREADY  out/in  1  read data handshake

Behaviour:
- Reset (sampled on ACLK): AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, BRESP=0, RVALID=0, RLAST=0, RRESP=0, RDATA=0. Both FSMs go to IDLE, even mid-burst. Memory contents are not cleared.
- Write FSM: W_IDLE -> (AW handshake; latch addr/len/size/burst; cnt=AWLEN; AWREADY=0) -> W_DATA -> (final beat) -> W_RESP -> (B handshake) -> W_IDLE. WREADY is 1 in W_DATA unless the arbiter grants the memory port to a read that cycle.
- Write beat: bytes with WSTRB[i]=1 are written the same cycle; other bytes keep their value. Burst ends after exactly AWLEN+1 beats. If WLAST does not match the final beat, the write FSM flags SLVERR; data is still written.
- Read FSM: R_IDLE -> (AR handshake; latch; ARREADY=0) -> R_ISSUE (memory read) -> R_DATA (RVALID=1, hold until RREADY) -> on handshake: R_ISSUE if beats remain, else R_IDLE. First RVALID appears 2 cycles after the AR handshake. Throughput is 1 beat per 2 cycles. RLAST=1 only on beat ARLEN.
- Address generation, per beat, with incr = 1<<size:
  - FIXED: address constant.
  - INCR: addr += incr.
  - WRAP: wrap_bytes = (len+1)<<size; addr = (addr & ~(wrap_bytes-1)) | ((addr+incr) & (wrap_bytes-1)).
  - Word index = addr>>BSH; all arithmetic is ADDR_W bits wide.
- Errors, checked once at the address phase and applying to the whole burst, with no memory access:
  - SLVERR if size > BSH.
  - SLVERR if burst = 3.
  - SLVERR if WRAP with len not in {1,3,7,15}.
  - SLVERR if WRAP with addr not aligned to size.
  - SLVERR if INCR crosses 4KB, i.e. (addr[11:0] + (len<<size)) > 0xFFF.
- Per-beat DECERR (2'b11): word index >= MEM_DEPTH. Write beat is dropped; read returns RDATA=0.
- Response priority:
  - BRESP is the worst of all beats, ranked DECERR > SLVERR > OKAY.
  - RRESP is reported per beat, with RDATA=0 on error.
- Arbiter (default): if a read issue and a write beat want the memory port in the same cycle, the read wins and WREADY=0 that cycle.
- The write and read channels are otherwise fully independent and run concurrently.

Optional Feature:
AXI4_SLV_RR_ARB_EN: when defined, the arbiter alternates round-robin on conflict cycles; a last-winner flag resets to "read won", so the first conflict after reset goes to the write. When undefined, fixed read priority as above.

Test Plan:
- INCR write AWADDR=0x10, AWLEN=3, AWSIZE=2, data 0xA0..0xA3, all strobes set; then INCR read of the same range -> RDATA 0xA0..0xA3, RLAST on beat 3 only, BRESP=0, first RVALID at AR handshake +2.
- WSTRB=4'b0101 write of 0xFFFFFFFF over 0x12345678 -> readback 0x12FF34FF... is wrong; required readback is 0x12FF56FF.
- WRAP read ARADDR=0x18, ARLEN=3, ARSIZE=2 -> address sequence 0x18, 0x1C, 0x10, 0x14. A WRAP with ARLEN=2 -> RRESP=2'b10 on all 3 beats.
- INCR write at 0xFF8, AWLEN=3, AWSIZE=2 (crosses 4KB) -> BRESP=2'b10 and memory unchanged. A write at word index MEM_DEPTH -> BRESP=2'b11.
- Concurrent 8-beat read and 8-beat write -> both complete with correct data; WREADY drops on conflict cycles (every conflict without the macro, alternating with it).
- ARESET asserted mid-read at beat 2 -> next cycle RVALID=0, ARREADY=1; a new burst then completes normally.

Source files
------------

// File: rtl/axi4_burst_slave_if.sv
// AXI4 bus bundle for axi4_burst_slave: write address/data/response and read address/data channels.
interface axi4_burst_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  localparam int NB = DATA_W / 8;

  logic [ADDR_W-1:0] AWADDR;
  logic [7:0]        AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic [NB-1:0]     WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  WDATA, WSTRB, WLAST, WVALID, BREADY,
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID
  );

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output WDATA, WSTRB, WLAST, WVALID, BREADY,
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi4_burst_slave.sv
// AXI4 leaf memory target: FIXED/INCR/WRAP bursts, byte strobes, single-port array shared by both FSMs.
// Define AXI4_SLV_RR_ARB_EN for round-robin arbitration on port conflicts (default: read wins).
//  state   | meaning
//  W_IDLE  | waiting for write address
//  W_DATA  | accepting write beats
//  W_RESP  | presenting BRESP
//  R_IDLE  | waiting for read address
//  R_ISSUE | reading the memory word for the current beat
//  R_DATA  | presenting the beat until RREADY
module axi4_burst_slave #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = 1024
) (
  input logic ACLK,
  input logic ARESET,
  axi4_burst_slave_if.slave axi
);
  localparam int NB  = DATA_W / 8;
  localparam int BSH = $clog2(NB);
  localparam int MW  = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [ADDR_W-1:0] w_addr, r_addr;
  logic [7:0]        w_len, r_len, w_cnt, r_cnt;
  logic [2:0]        w_size, r_size;
  logic [1:0]        w_burst, r_burst, w_resp, w_beat_resp;
  logic              w_aerr, r_aerr, aw_err, ar_err;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              rlast_q;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic              w_ok, r_ok, wr_req, rd_req, rd_gnt, wr_block, wready_c, w_beat, rd_step;
  logic [MW-1:0]     w_idx, r_idx;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                                  input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_W-1:0] incr, mask;
    incr = ADDR_W'(1) << size;
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    case (burst)
      2'd1:    next_addr = a + incr;
      2'd2:    next_addr = (a & ~mask) | ((a + incr) & mask);
      default: next_addr = a;
    endcase
  endfunction

  // Burst-wide errors; a flagged burst never touches the array.
  function automatic logic addr_err(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                    input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_W-1:0] incr;
    logic [23:0]       span;
    incr = ADDR_W'(1) << size;
    span = 24'(a[11:0]) + (24'(len) << size);
    addr_err = (size > 3'(BSH)) || (burst == 2'd3)
            || (burst == 2'd2 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            || (burst == 2'd2 && (a & (incr - ADDR_W'(1))) != '0)
            || (burst == 2'd1 && span > 24'hFFF);
  endfunction

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    worst = (a > b) ? a : b;
  endfunction

  assign aw_err = addr_err(axi.AWADDR, axi.AWLEN, axi.AWSIZE, axi.AWBURST);
  assign ar_err = addr_err(axi.ARADDR, axi.ARLEN, axi.ARSIZE, axi.ARBURST);
  assign w_ok   = 32'(w_addr >> BSH) < 32'(MEM_DEPTH);
  assign r_ok   = 32'(r_addr >> BSH) < 32'(MEM_DEPTH);
  assign w_idx  = MW'(w_addr >> BSH);
  assign r_idx  = MW'(r_addr >> BSH);
  assign wr_req = (w_state == W_DATA) && axi.WVALID && !w_aerr && w_ok;
  assign rd_req = (r_state == R_ISSUE) && !r_aerr && r_ok;

`ifdef AXI4_SLV_RR_ARB_EN
  logic last_rd;

  always_ff @(posedge ACLK) begin
    if (ARESET)                last_rd <= 1'b1;
    else if (rd_req && wr_req) last_rd <= rd_gnt;
  end
`endif

  always_comb begin
    w_next   = w_state;
    r_next   = r_state;
    rd_gnt   = rd_req;
    wr_block = 1'b0;
    if (rd_req && wr_req) begin
`ifdef AXI4_SLV_RR_ARB_EN
      if (last_rd) rd_gnt = 1'b0;
      else         wr_block = 1'b1;
`else
      wr_block = 1'b1;
`endif
    end
    wready_c = (w_state == W_DATA) && !wr_block;
    w_beat   = wready_c && axi.WVALID;
    rd_step  = (r_state == R_ISSUE) && (rd_gnt || !rd_req);
    case (w_state)
      W_IDLE:  if (axi.AWVALID) w_next = W_DATA;
      W_DATA:  if (w_beat && w_cnt == 8'd0) w_next = W_RESP;
      W_RESP:  if (axi.BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    case (r_state)
      R_IDLE:  if (axi.ARVALID) r_next = R_ISSUE;
      R_ISSUE: if (rd_step) r_next = R_DATA;
      R_DATA:  if (axi.RREADY) r_next = (r_cnt == 8'd0) ? R_IDLE : R_ISSUE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_beat_resp = w_resp;
    if (!w_aerr && !w_ok) w_beat_resp = 2'b11;
    if (axi.WLAST != (w_cnt == 8'd0)) w_beat_resp = worst(w_beat_resp, 2'b10);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_aerr  <= 1'b0;
      w_resp  <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_aerr  <= 1'b0;
      rdata_q <= '0;
      rresp_q <= '0;
      rlast_q <= 1'b0;
    end else begin
      if (w_state == W_IDLE && axi.AWVALID) begin
        w_addr  <= axi.AWADDR;
        w_len   <= axi.AWLEN;
        w_size  <= axi.AWSIZE;
        w_burst <= axi.AWBURST;
        w_cnt   <= axi.AWLEN;
        w_aerr  <= aw_err;
        w_resp  <= aw_err ? 2'b10 : 2'b00;
      end
      if (w_beat) begin
        w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
        w_cnt  <= w_cnt - 8'd1;
        w_resp <= w_beat_resp;
      end
      if (r_state == R_IDLE && axi.ARVALID) begin
        r_addr  <= axi.ARADDR;
        r_len   <= axi.ARLEN;
        r_size  <= axi.ARSIZE;
        r_burst <= axi.ARBURST;
        r_cnt   <= axi.ARLEN;
        r_aerr  <= ar_err;
      end
      if (rd_step) begin
        rdata_q <= rd_gnt ? mem[r_idx] : '0;
        rresp_q <= r_aerr ? 2'b10 : (r_ok ? 2'b00 : 2'b11);
        rlast_q <= (r_cnt == 8'd0);
      end
      if (r_state == R_DATA && axi.RREADY) begin
        r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
        r_cnt  <= r_cnt - 8'd1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESET && w_beat && wr_req) begin
      for (int i = 0; i < NB; i++)
        if (axi.WSTRB[i]) mem[w_idx][8*i +: 8] <= axi.WDATA[8*i +: 8];
    end
  end

  assign axi.AWREADY = (w_state == W_IDLE);
  assign axi.WREADY  = wready_c;
  assign axi.BVALID  = (w_state == W_RESP);
  assign axi.BRESP   = w_resp;
  assign axi.ARREADY = (r_state == R_IDLE);
  assign axi.RVALID  = (r_state == R_DATA);
  assign axi.RDATA   = rdata_q;
  assign axi.RRESP   = rresp_q;
  assign axi.RLAST   = rlast_q;
endmodule

// File: tb/tb_axi4_burst_slave.sv
// Directed bench for axi4_burst_slave (DATA_W=32, ADDR_W=16, MEM_DEPTH=1024).
module tb_axi4_burst_slave;
  logic aclk   = 1'b0;
  logic areset = 1'b1;
  int   n_chk = 0, n_fail = 0, w_stalls = 0, rlat = 0;
  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] rbuf [16];
  logic [1:0]  rrsp [16];
  logic        rlst [16];
  logic [1:0]  bresp;

  axi4_burst_slave_if #(.DATA_W(32), .ADDR_W(16)) bus ();

  axi4_burst_slave #(.DATA_W(32), .ADDR_W(16), .MEM_DEPTH(1024)) dut (
    .ACLK   (aclk),
    .ARESET (areset),
    .axi    (bus)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input int wl_beat, output logic [1:0] resp);
    int t;
    bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size; bus.AWBURST = burst;
    bus.AWVALID = 1'b1;
    t = 0;
    do begin @(negedge aclk); t++; end while (!bus.AWREADY && t < 50);
    chk("aw_ready", 32'(bus.AWREADY), 32'd1);
    @(posedge aclk); #1 bus.AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.WDATA = wbuf[i]; bus.WSTRB = sbuf[i]; bus.WLAST = (i == wl_beat); bus.WVALID = 1'b1;
      t = 0;
      @(negedge aclk);
      while (!bus.WREADY && t < 50) begin w_stalls++; t++; @(negedge aclk); end
      chk("w_ready", 32'(bus.WREADY), 32'd1);
      @(posedge aclk); #1;
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.BREADY = 1'b1;
    t = 0;
    do begin @(negedge aclk); t++; end while (!bus.BVALID && t < 50);
    chk("b_valid", 32'(bus.BVALID), 32'd1);
    resp = bus.BRESP;
    @(posedge aclk); #1 bus.BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
    int t;
    bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size; bus.ARBURST = burst;
    bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
    t = 0;
    do begin @(negedge aclk); t++; end while (!bus.ARREADY && t < 50);
    chk("ar_ready", 32'(bus.ARREADY), 32'd1);
    @(posedge aclk); #1 bus.ARVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      do begin @(negedge aclk); t++; end while (!bus.RVALID && t < 50);
      chk("r_valid", 32'(bus.RVALID), 32'd1);
      if (i == 0) rlat = t;
      rbuf[i] = bus.RDATA; rrsp[i] = bus.RRESP; rlst[i] = bus.RLAST;
      @(posedge aclk); #1;
    end
    bus.RREADY = 1'b0;
  endtask

  task automatic wait_rvalid(input string tag);
    int t;
    t = 0;
    do begin @(negedge aclk); t++; end while (!bus.RVALID && t < 50);
    chk(tag, 32'(bus.RVALID), 32'd1);
  endtask

  initial begin
    bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_awready", 32'(bus.AWREADY), 32'd1);
    chk("rst_arready", 32'(bus.ARREADY), 32'd1);
    chk("rst_wready",  32'(bus.WREADY),  32'd0);
    chk("rst_bvalid",  32'(bus.BVALID),  32'd0);
    chk("rst_bresp",   32'(bus.BRESP),   32'd0);
    chk("rst_rvalid",  32'(bus.RVALID),  32'd0);
    chk("rst_rlast",   32'(bus.RLAST),   32'd0);
    chk("rst_rresp",   32'(bus.RRESP),   32'd0);
    chk("rst_rdata",   bus.RDATA,        32'd0);
    @(posedge aclk); #1 areset = 1'b0;

    // INCR write then readback
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + 32'(i); sbuf[i] = 4'hF; end
    do_write(16'h0010, 8'd3, 3'd2, 2'd1, 3, bresp);
    chk("incr_bresp", 32'(bresp), 32'd0);
    do_read(16'h0010, 8'd3, 3'd2, 2'd1);
    chk("incr_rlat", 32'(rlat), 32'd2);
    for (int i = 0; i < 4; i++) begin
      chk("incr_rdata", rbuf[i], 32'hA0 + 32'(i));
      chk("incr_rresp", 32'(rrsp[i]), 32'd0);
      chk("incr_rlast", 32'(rlst[i]), 32'(i == 3));
    end

    // byte strobes
    wbuf[0] = 32'h12345678; sbuf[0] = 4'hF;
    do_write(16'h0040, 8'd0, 3'd2, 2'd1, 0, bresp);
    wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'b0101;
    do_write(16'h0040, 8'd0, 3'd2, 2'd1, 0, bresp);
    chk("strb_bresp", 32'(bresp), 32'd0);
    do_read(16'h0040, 8'd0, 3'd2, 2'd1);
    chk("strb_rdata", rbuf[0], 32'h12FF56FF);
    sbuf[0] = 4'hF;

    // WRAP: 0x18,0x1C,0x10,0x14 -> words A2,A3,A0,A1
    do_read(16'h0018, 8'd3, 3'd2, 2'd2);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_rdata", rbuf[i], 32'hA0 + 32'((i + 2) % 4));
      chk("wrap_rresp", 32'(rrsp[i]), 32'd0);
    end
    do_read(16'h0010, 8'd2, 3'd2, 2'd2);
    for (int i = 0; i < 3; i++) begin
      chk("wrap_len2_rresp", 32'(rrsp[i]), 32'd2);
      chk("wrap_len2_rdata", rbuf[i], 32'd0);
      chk("wrap_len2_rlast", 32'(rlst[i]), 32'(i == 2));
    end
    do_read(16'h0060, 8'd0, 3'd3, 2'd1);
    chk("size_err_rresp", 32'(rrsp[0]), 32'd2);

    // 4KB crossing leaves memory intact
    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222; sbuf[1] = 4'hF;
    do_write(16'h0FF8, 8'd1, 3'd2, 2'd1, 1, bresp);
    chk("pre4k_bresp", 32'(bresp), 32'd0);
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hDEAD0000 + 32'(i); sbuf[i] = 4'hF; end
    do_write(16'h0FF8, 8'd3, 3'd2, 2'd1, 3, bresp);
    chk("x4k_bresp", 32'(bresp), 32'd2);
    do_read(16'h0FF8, 8'd1, 3'd2, 2'd1);
    chk("x4k_word0", rbuf[0], 32'h11111111);
    chk("x4k_word1", rbuf[1], 32'h22222222);

    // DECERR beyond MEM_DEPTH, no aliasing onto word 0
    wbuf[0] = 32'h01020304;
    do_write(16'h0000, 8'd0, 3'd2, 2'd1, 0, bresp);
    wbuf[0] = 32'h5A5A5A5A;
    do_write(16'h1000, 8'd0, 3'd2, 2'd1, 0, bresp);
    chk("decerr_bresp", 32'(bresp), 32'd3);
    do_read(16'h1000, 8'd0, 3'd2, 2'd1);
    chk("decerr_rresp", 32'(rrsp[0]), 32'd3);
    chk("decerr_rdata", rbuf[0], 32'd0);
    do_read(16'h0000, 8'd0, 3'd2, 2'd1);
    chk("decerr_alias", rbuf[0], 32'h01020304);

    // WLAST on the wrong beat: SLVERR but data kept
    wbuf[0] = 32'h33; wbuf[1] = 32'h44;
    do_write(16'h0080, 8'd1, 3'd2, 2'd1, 0, bresp);
    chk("wlast_bresp", 32'(bresp), 32'd2);
    do_read(16'h0080, 8'd1, 3'd2, 2'd1);
    chk("wlast_word0", rbuf[0], 32'h33);
    chk("wlast_word1", rbuf[1], 32'h44);

    // FIXED burst keeps hitting one word
    wbuf[0] = 32'hB0; wbuf[1] = 32'hB1; wbuf[2] = 32'hB2;
    do_write(16'h0060, 8'd2, 3'd2, 2'd0, 2, bresp);
    chk("fixed_bresp", 32'(bresp), 32'd0);
    do_read(16'h0060, 8'd1, 3'd2, 2'd0);
    chk("fixed_rdata0", rbuf[0], 32'hB2);
    chk("fixed_rdata1", rbuf[1], 32'hB2);

    // concurrent 8-beat read and write
    for (int i = 0; i < 8; i++) begin wbuf[i] = 32'hD0 + 32'(i); sbuf[i] = 4'hF; end
    do_write(16'h0200, 8'd7, 3'd2, 2'd1, 7, bresp);
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hC0 + 32'(i);
    w_stalls = 0;
    fork
      do_write(16'h0100, 8'd7, 3'd2, 2'd1, 7, bresp);
      do_read(16'h0200, 8'd7, 3'd2, 2'd1);
    join
    chk("conc_bresp", 32'(bresp), 32'd0);
    chk("conc_stalled", 32'(w_stalls > 0), 32'd1);
    for (int i = 0; i < 8; i++) chk("conc_rdata", rbuf[i], 32'hD0 + 32'(i));
    do_read(16'h0100, 8'd7, 3'd2, 2'd1);
    for (int i = 0; i < 8; i++) chk("conc_wdata", rbuf[i], 32'hC0 + 32'(i));

    // reset in the middle of a read burst
    bus.ARADDR = 16'h0200; bus.ARLEN = 8'd7; bus.ARSIZE = 3'd2; bus.ARBURST = 2'd1;
    bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
    @(posedge aclk); #1 bus.ARVALID = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wait_rvalid("mid_rvalid");
      @(posedge aclk); #1;
    end
    wait_rvalid("mid_rvalid");
    chk("mid_beat2", bus.RDATA, 32'hD2);
    areset = 1'b1;
    @(posedge aclk); #1 areset = 1'b0; bus.RREADY = 1'b0;
    @(negedge aclk);
    chk("mid_rst_rvalid",  32'(bus.RVALID),  32'd0);
    chk("mid_rst_arready", 32'(bus.ARREADY), 32'd1);
    chk("mid_rst_rdata",   bus.RDATA,        32'd0);
    do_read(16'h0200, 8'd7, 3'd2, 2'd1);
    for (int i = 0; i < 8; i++) begin
      chk("post_rst_rdata", rbuf[i], 32'hD0 + 32'(i));
      chk("post_rst_rlast", 32'(rlst[i]), 32'(i == 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
